// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_W = 32;
  localparam int NBYTES = WORD_W / 8;
endpackage

// File: rtl/dmem_ram_array.sv
// DEPTH x 32 word RAM: synchronous byte-enabled write, registered read, no reset.
module dmem_ram_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 32,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [NBYTES-1:0] be,
  input  logic [IW-1:0]     idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] ram [DEPTH];

  // Read-before-write: a store's own rdata is the old word, which the top masks.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= ram[idx];
      if (we) begin
        for (int b = 0; b < NBYTES; b++) begin
          if (be[b]) ram[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end
endmodule

// File: rtl/dmem_responder.sv
// Valid/ready data-memory target with programmable wait states and
// misaligned / out-of-range error reporting.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [NBYTES-1:0] req_be,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_INIT = (LATENCY == 0) ? '0 : CW'(LATENCY - 1);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic              l_we, l_err, rd_ok;
  logic [IW-1:0]     l_idx;
  logic [WORD_W-1:0] l_wdata;
  logic [NBYTES-1:0] l_be;

  logic              accept, req_err;
  logic              ram_en, ram_we;
  logic [IW-1:0]     ram_idx;
  logic [WORD_W-1:0] ram_wdata, ram_rdata;
  logic [NBYTES-1:0] ram_be;

  assign accept  = req_valid && req_ready;
  // DEPTH is a power of two, so any set bit above the index means out of range.
  assign req_err = (req_addr[1:0] != 2'b00) || (|req_addr[31:IW+2]);

  // With zero wait states the RAM is accessed on the accepting edge itself,
  // so it must see the live request rather than the latched copy.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = l_we;
    ram_idx   = l_idx;
    ram_be    = l_be;
    ram_wdata = l_wdata;
    if (LATENCY == 0) begin
      ram_en    = accept && !req_err;
      ram_we    = req_we;
      ram_idx   = req_addr[IW+1:2];
      ram_be    = req_be;
      ram_wdata = req_wdata;
    end else begin
      ram_en    = (state == WAIT) && (cnt == '0) && !l_err;
    end
  end

  dmem_ram_array #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .be    (ram_be),
    .idx   (ram_idx),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign resp_rdata = rd_ok ? ram_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      l_we       <= 1'b0;
      l_err      <= 1'b0;
      l_idx      <= '0;
      l_wdata    <= '0;
      l_be       <= '0;
      rd_ok      <= 1'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          l_we      <= req_we;
          l_err     <= req_err;
          l_idx     <= req_addr[IW+1:2];
          l_wdata   <= req_wdata;
          l_be      <= req_be;
          req_ready <= 1'b0;
          busy      <= 1'b1;
          if (LATENCY == 0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= req_err;
            rd_ok      <= !req_we && !req_err;
          end else begin
            state <= WAIT;
            cnt   <= CNT_INIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= l_err;
            rd_ok      <= !l_we && !l_err;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: if (resp_ready) begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          rd_ok      <= 1'b0;
          req_ready  <= 1'b1;
          busy       <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: directed scenarios plus random traffic against a
// word-array memory model, on a LATENCY=2 and a LATENCY=0 instance.
module tb_dmem_responder;
  localparam int DEPTH = 32;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        req_ready, resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;

  logic        req_valid0 = 1'b0, req_we0 = 1'b0, resp_ready0 = 1'b0;
  logic [31:0] req_addr0 = '0, req_wdata0 = '0;
  logic [3:0]  req_be0 = '0;
  logic        req_ready0, resp_valid0, resp_err0, busy0;
  logic [31:0] resp_rdata0;

  logic [31:0] mem [DEPTH];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .busy(busy)
  );

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_we(req_we0), .req_addr(req_addr0), .req_wdata(req_wdata0), .req_be(req_be0),
    .resp_valid(resp_valid0), .resp_ready(resp_ready0), .resp_rdata(resp_rdata0),
    .resp_err(resp_err0), .busy(busy0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_ram(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (dut.u_ram.ram[i] !== mem[i]) bad++;
    check(tag, 32'(bad), 32'd0);
  endtask

  // One full transaction on the LATENCY=2 instance, checked against the model.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input int stall);
    logic        err_e;
    logic [31:0] rd_e;
    int          cyc;
    err_e = (addr % 4 != 0) || (addr / 4 >= DEPTH);
    rd_e  = 32'd0;
    if (!we && !err_e) rd_e = mem[addr / 4];
    @(negedge clk);
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    @(posedge clk); #1;
    // Junk on the request bus while busy must be ignored.
    req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom); req_we = ~we;
    cyc = 1;
    while (!resp_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    req_valid = 1'b0;
    check("resp_latency", 32'(cyc), 32'(LAT + 1));
    check("resp_rdata", resp_rdata, rd_e);
    check("resp_err", {31'd0, resp_err}, {31'd0, err_e});
    check("busy_resp", {31'd0, busy}, 32'd1);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check("stall_valid", {31'd0, resp_valid}, 32'd1);
      check("stall_rdata", resp_rdata, rd_e);
      check("stall_err", {31'd0, resp_err}, {31'd0, err_e});
      check("stall_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("resp_valid_drop", {31'd0, resp_valid}, 32'd0);
    check("req_ready_back", {31'd0, req_ready}, 32'd1);
    if (we && !err_e)
      for (int b = 0; b < 4; b++) if (be[b]) mem[addr / 4][8*b +: 8] = wdata[8*b +: 8];
  endtask

  initial begin
    logic [31:0] exp_d [3];
    logic        exp_e [3];
    logic [31:0] a_q [3], d_q [3];
    logic        w_q [3];
    int          acc_cyc [3];
    int          acc_n, resp_n;
    logic        acc;

    #1;
    check("rst_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", {31'd0, resp_err}, 32'd0);

    for (int i = 0; i < DEPTH; i++) txn(1'b1, 32'(i * 4), $urandom, 4'hF, 0);
    check_ram("ram_init");

    // Store then load
    txn(1'b1, 32'h8, 32'hDEADBEEF, 4'hF, 0);
    txn(1'b0, 32'h8, 32'h0, 4'h0, 0);
    check("ram2_store", dut.u_ram.ram[2], 32'hDEADBEEF);

    // Byte enables
    txn(1'b1, 32'h8, 32'h11223344, 4'b0101, 0);
    check("ram2_be5", dut.u_ram.ram[2], 32'hDE22BE44);
    txn(1'b1, 32'h8, 32'hFFFFFFFF, 4'b0000, 1);
    check("ram2_be0", dut.u_ram.ram[2], 32'hDE22BE44);

    // Errors
    txn(1'b0, 32'h6, 32'h0, 4'hF, 0);
    txn(1'b1, 32'h80, 32'h12345678, 4'hF, 0);
    check_ram("ram_err_store");

    // Backpressure
    txn(1'b0, 32'h8, 32'h0, 4'h0, 5);

    // Reset while the store is still waiting
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h4; req_wdata = ~mem[1]; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_valid", {31'd0, resp_valid}, 32'd0);
    check("midrst_rdata", resp_rdata, 32'd0);
    check("midrst_err", {31'd0, resp_err}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_ready", {31'd0, req_ready}, 32'd1);
    check("midrst_ram1", dut.u_ram.ram[1], mem[1]);
    txn(1'b0, 32'h4, 32'h0, 4'h0, 0);

    // Zero-latency instance, req_valid held high across three requests
    w_q[0] = 1'b1; a_q[0] = 32'h8; d_q[0] = 32'hCAFEF00D; exp_d[0] = 32'h0;        exp_e[0] = 1'b0;
    w_q[1] = 1'b0; a_q[1] = 32'h8; d_q[1] = 32'h0;        exp_d[1] = 32'hCAFEF00D; exp_e[1] = 1'b0;
    w_q[2] = 1'b0; a_q[2] = 32'h9; d_q[2] = 32'h0;        exp_d[2] = 32'h0;        exp_e[2] = 1'b1;
    acc_n = 0; resp_n = 0;
    @(negedge clk);
    req_valid0 = 1'b1; req_we0 = w_q[0]; req_addr0 = a_q[0]; req_wdata0 = d_q[0]; req_be0 = 4'hF;
    resp_ready0 = 1'b1;
    for (int c = 0; c < 20 && resp_n < 3; c++) begin
      if (c > 0) @(negedge clk);
      if (resp_valid0 && resp_n < 3 && acc_n > resp_n) begin
        check("l0_resp_lat", 32'(c - acc_cyc[resp_n]), 32'd1);
        check("l0_rdata", resp_rdata0, exp_d[resp_n]);
        check("l0_err", {31'd0, resp_err0}, {31'd0, exp_e[resp_n]});
        resp_n++;
      end
      acc = req_valid0 && req_ready0;
      @(posedge clk); #1;
      if (acc) begin
        acc_cyc[acc_n] = c;
        acc_n++;
        if (acc_n < 3) begin
          req_we0 = w_q[acc_n]; req_addr0 = a_q[acc_n]; req_wdata0 = d_q[acc_n];
        end else begin
          req_valid0 = 1'b0;
        end
      end
    end
    resp_ready0 = 1'b0;
    check("l0_accepts", 32'(acc_n), 32'd3);
    check("l0_resps", 32'(resp_n), 32'd3);
    if (acc_n == 3) begin
      check("l0_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd2);
      check("l0_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd2);
    end

    // Random traffic on the LATENCY=2 instance
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, DEPTH + 3)) * 4;
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      txn(1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(0, 3)));
    end
    check_ram("ram_random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder for the MIPS core's load/store port: the target end of a valid/ready request/response handshake that the core (or a bench) initiates.
- Holds a word-addressed RAM, applies byte-enabled writes and returns read data after a programmable number of wait states.
- Flags misaligned and out-of-range accesses.
- Lets the core and benches exercise a multi-cycle memory instead of the zero-latency array.

Parameters:
DEPTH, 32, number of 32-bit words; power of two, minimum 2
LATENCY, 2, wait cycles between request acceptance and response; 0 allowed

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data
req_be  input  4  byte enables for store; bit i covers bits [8i+7:8i]
resp_valid  output  1  response present
resp_ready  input  1  initiator accepts response
resp_rdata  output  32  load data; 0 for stores and errors
resp_err  output  1  access was misaligned or out of range
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE; the wait counter clears.
  - resp_valid=0, resp_rdata=0, resp_err=0, busy=0, req_ready=1 after reset deasserts.
  - RAM contents are not cleared.
  - Reset during WAIT or RESP drops the transaction. A pending store is not performed unless its RAM write edge has already occurred.
- State machine:
  - IDLE: req_ready=1. On req_valid&&req_ready, latch we/addr/wdata/be and compute err. If LATENCY==0 go to RESP, else go to WAIT with counter=LATENCY-1.
  - WAIT: req_ready=0; decrement counter each cycle; when counter==0 go to RESP.
  - RESP: resp_valid=1; resp_rdata and resp_err stable until resp_ready. On resp_valid&&resp_ready go to IDLE, and resp_valid falls next cycle.
- Access timing:
  - The RAM access (read sample or byte-enabled write) happens on the edge that enters RESP.
  - Load-to-response latency is LATENCY+1 cycles after the accepting edge.
- Throughput: req_ready is low in WAIT and RESP. No request is accepted in the cycle a response handshakes, so the minimum issue interval is LATENCY+2 cycles.
- Error rule: err = (req_addr[1:0]!=0) || (req_addr[31:2] >= DEPTH).
  - On error, the store is suppressed and resp_rdata=0.
  - req_be is not checked for errors.
- Store with req_be=4'b0000: no RAM change, normal response, err=0 unless the address rule fires.
- Loads ignore req_be and return the full word.
- Index = req_addr[$clog2(DEPTH)+1:2]; no wrap-around, since out-of-range addresses are errors.
- Counter width = max(1, $clog2(LATENCY+1)); it never underflows.
- Inputs are don't-care outside IDLE; changes to req_* while busy have no effect.
- The internal RAM array is named ram so benches can peek at it hierarchically.

Decomposition:
- Shared package dmem_pkg: state encoding (IDLE, WAIT, RESP) and the word-size/byte-lane constants.
- One sub-module, dmem_ram_array:
  - DEPTH×32 array `ram`, synchronous byte-enabled write, registered read.
  - Ports clk, en, we, be, idx, wdata, rdata; no reset.
- The FSM, error check and handshake stay in dmem_responder.

Test Plan:
- Store, then load, LATENCY=2: store addr=0x8, wdata=0xDEADBEEF, be=4'hF; then load addr=0x8 → each response arrives 3 cycles after acceptance; the load returns resp_rdata=0xDEADBEEF, resp_err=0; ram[2]=0xDEADBEEF.
- Byte enables: ram[2]=0xDEADBEEF; store 0x11223344 with be=4'b0101 → ram[2]=0xDE22BE44. Store with be=0 → ram[2] unchanged, err=0.
- Errors: load addr=0x6 → resp_err=1, rdata=0. Store addr=0x80 with DEPTH=32 → resp_err=1 and no ram word changes.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP → resp_valid, rdata and err stay stable and req_ready stays 0; raise resp_ready → IDLE next cycle and req_ready=1.
- Back-to-back with LATENCY=0: req_valid held high with two loads → accepts 2 cycles apart; first resp_valid 1 cycle after acceptance.
- Reset mid-WAIT: assert rst one cycle after accepting a store to 0x4 → outputs go to 0 immediately, ram[1] is unchanged, and the next request is accepted normally.
